// File: rtl/parall_interf_regbank_pkg.sv
// Shared constants and address-map helpers for the parallel host register bank.
// Latency: n/a (package only).
// Backpressure: n/a.
package parall_interf_pkg;

  localparam int DEF_DW          = 16;
  localparam int DEF_AW          = 8;
  localparam int DEF_NREG        = 8;
  localparam int DEF_SYNC_STAGES = 3;

  // The three special words sit directly above the control registers.
  function automatic int STATUS_ADDR(input int nreg);
    return nreg;
  endfunction

  function automatic int PEND_ADDR(input int nreg);
    return nreg + 1;
  endfunction

  function automatic int EN_ADDR(input int nreg);
    return nreg + 2;
  endfunction

endpackage

// File: rtl/parall_interf_regbank_bus_sync.sv
// Multi-flop synchroniser for one asynchronous host strobe, with falling-edge detect.
// Latency: STAGES sclk edges to level, fall asserted in the cycle the level first drops.
// Backpressure: none; pulses shorter than the sync window may be lost but never duplicated.
//
// Ports:
//   sclk, rst_n : clock and asynchronous active-low reset
//   raw         : asynchronous input
//   level       : synchronised level (last sync flop)
//   fall        : one-cycle pulse, level low while its delayed copy is still high
module bus_sync #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b1
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              level_d;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RST_VAL}};
      level_d <= RST_VAL;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], raw};
      level_d <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  // Built only from flop outputs, so it is glitch-free and lasts exactly one
  // cycle per high-to-low transition of the synchronised level.
  assign fall  = ~sync_q[STAGES-1] & level_d;

endmodule

// File: rtl/parall_interf_regbank.sv
// Host-facing register bank: NREG RW control words, RO status, W1C pend + RW enable, level irq.
// Latency: commits SYNC_STAGES sclk edges after the strobe is first sampled low; irq 2 edges after irq_src.
// Backpressure: none; host must hold strobes low/high for SYNC_STAGES+1 cycles, one commit per access.
//
// Ports:
//   sclk, rst_n           : clock, asynchronous active-low reset
//   cs_n, rd_n, wr_n      : asynchronous host strobes (active low)
//   addr, data            : asynchronous host address, bidirectional host data
//   ctrl_q                : flattened control registers, register i at [i*DW +: DW]
//   status_in             : read-only status word, sampled at read commit
//   irq_src               : per-bit interrupt set pulses (sclk domain)
//   wr_stb, wr_addr       : write-commit pulse and last written address
//   irq                   : registered |(pend & en)
module parall_interf_regbank
  import parall_interf_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int NREG        = DEF_NREG,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               cs_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [AW-1:0]      addr,
  inout  wire  [DW-1:0]      data,
  output logic [NREG*DW-1:0] ctrl_q,
  input  logic [DW-1:0]      status_in,
  input  logic [DW-1:0]      irq_src,
  output logic               wr_stb,
  output logic [AW-1:0]      wr_addr,
  output logic               irq
);

  if (SYNC_STAGES < 2 || NREG + 3 > 2**AW) begin : g_bad_param
    $error("parall_interf_regbank: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Strobe synchronisers (reset high = idle bus)
  // ---------------------------------------------------------------------------
  logic s_cs, s_rd, s_wr;
  logic rd_fall, wr_fall, cs_fall_unused;

  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .sclk (sclk), .rst_n(rst_n), .raw(cs_n), .level(s_cs), .fall(cs_fall_unused)
  );
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .sclk (sclk), .rst_n(rst_n), .raw(rd_n), .level(s_rd), .fall(rd_fall)
  );
  bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
    .sclk (sclk), .rst_n(rst_n), .raw(wr_n), .level(s_wr), .fall(wr_fall)
  );

  // ---------------------------------------------------------------------------
  // Address/data delay lines, same depth as the strobes so they stay aligned
  // ---------------------------------------------------------------------------
  logic [AW-1:0] addr_pipe [SYNC_STAGES];
  logic [DW-1:0] data_pipe [SYNC_STAGES];
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_pipe[i] <= '0;
        data_pipe[i] <= '0;
      end
    end else begin
      addr_pipe[0] <= addr;
      data_pipe[0] <= data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_pipe[i] <= addr_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign s_addr = addr_pipe[SYNC_STAGES-1];
  assign s_data = data_pipe[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Commit decode: a commit needs the matching strobe edge, chip select, and the
  // other strobe idle, so "both strobes low" never commits anything.
  // ---------------------------------------------------------------------------
  logic wr_commit, rd_commit;
  logic hit_status, hit_pend, hit_en;

  assign wr_commit  = wr_fall & ~s_cs & s_rd;
  assign rd_commit  = rd_fall & ~s_cs & s_wr;
  assign hit_status = (s_addr == AW'(STATUS_ADDR(NREG)));
  assign hit_pend   = (s_addr == AW'(PEND_ADDR(NREG)));
  assign hit_en     = (s_addr == AW'(EN_ADDR(NREG)));

  // ---------------------------------------------------------------------------
  // Register file, interrupt state and write-commit outputs
  // ---------------------------------------------------------------------------
  logic [DW-1:0] pend, en;
  logic [DW-1:0] clr;

  assign clr = (wr_commit && hit_pend) ? s_data : '0;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      en      <= '0;
      pend    <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      irq     <= 1'b0;
    end else begin
      wr_stb <= wr_commit;
      if (wr_commit) begin
        wr_addr <= s_addr;
      end
      for (int i = 0; i < NREG; i++) begin
        if (wr_commit && s_addr == AW'(i)) begin
          ctrl_q[i*DW +: DW] <= s_data;
        end
      end
      if (wr_commit && hit_en) begin
        en <= s_data;
      end
      // OR-ing irq_src after the clear mask lets a same-cycle set win.
      pend <= (pend & ~clr) | irq_src;
      irq  <= |(pend & en);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: data and enable are both registered so the pad driver never
  // sees a combinational glitch.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rsel;
  logic [DW-1:0] rdata;
  logic          oe;

  always_comb begin
    rsel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (s_addr == AW'(i)) begin
        rsel = ctrl_q[i*DW +: DW];
      end
    end
    if (hit_status) rsel = status_in;
    if (hit_pend)   rsel = pend;
    if (hit_en)     rsel = en;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      oe    <= 1'b0;
    end else begin
      if (rd_commit) begin
        rdata <= rsel;
      end
      // Release has priority: the drive drops as soon as the host deselects.
      if (s_cs || s_rd) begin
        oe <= 1'b0;
      end else if (rd_commit) begin
        oe <= 1'b1;
      end
    end
  end

  assign data = oe ? rdata : {DW{1'bz}};

endmodule

// File: tb/tb_parall_interf_regbank.sv
module tb_parall_interf_regbank;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int NREG = 8;
  localparam int SS   = 3;

  logic               sclk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cs_n = 1'b1;
  logic               rd_n = 1'b1;
  logic               wr_n = 1'b1;
  logic [AW-1:0]      addr = '0;
  wire  [DW-1:0]      data_bus;
  logic [NREG*DW-1:0] ctrl_q;
  logic [DW-1:0]      status_in = '0;
  logic [DW-1:0]      irq_src = '0;
  logic               wr_stb;
  logic [AW-1:0]      wr_addr;
  logic               irq;

  logic               host_drv = 1'b0;
  logic [DW-1:0]      host_dat = '0;

  assign data_bus = host_drv ? host_dat : {DW{1'bz}};

  parall_interf_regbank #(.DW(DW), .AW(AW), .NREG(NREG), .SYNC_STAGES(SS)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .addr      (addr),
    .data      (data_bus),
    .ctrl_q    (ctrl_q),
    .status_in (status_in),
    .irq_src   (irq_src),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .irq       (irq)
  );

  initial forever #5 sclk = ~sclk;

  // Count write strobe pulses on the falling clock edge.
  int stb_cnt = 0;
  always @(negedge sclk) if (wr_stb === 1'b1) stb_cnt++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; host_dat = d; host_drv = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    cyc(SS + 2);
    wr_n = 1'b1; cs_n = 1'b1; host_drv = 1'b0;
    cyc(SS + 2);
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    cyc(SS + 2);
    d = data_bus;
    rd_n = 1'b1; cs_n = 1'b1;
    cyc(SS + 2);
  endtask

  logic [127:0] exp_ctrl;
  logic [DW-1:0] rd_val;
  int            base;

  initial begin
    exp_ctrl = '0;

    // ---------------- reset state ----------------
    cyc(3);
    check("rst_ctrl_q", ctrl_q, 128'h0);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_oe", dut.oe, 1'b0);
    rst_n = 1'b1;
    cyc(5);

    // ---------------- write then read, with latency ----------------
    base = stb_cnt;
    addr = 8'd3; host_dat = 16'hA5A5; host_drv = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    cyc(SS);
    check("wr_before_k3", ctrl_q[3*DW +: DW], 16'h0000);
    cyc(1);
    check("wr_at_k3", ctrl_q[3*DW +: DW], 16'hA5A5);
    check("wr_stb_at_k3", wr_stb, 1'b1);
    check("wr_addr_at_k3", wr_addr, 8'd3);
    cyc(1);
    check("wr_stb_one_cycle", wr_stb, 1'b0);
    wr_n = 1'b1; cs_n = 1'b1; host_drv = 1'b0;
    cyc(SS + 2);
    check("wr_stb_count", stb_cnt - base, 1);
    exp_ctrl[3*DW +: DW] = 16'hA5A5;

    addr = 8'd3; cs_n = 1'b0; rd_n = 1'b0;
    cyc(SS);
    check("rd_oe_before_k3", dut.oe, 1'b0);
    cyc(1);
    check("rd_oe_at_k3", dut.oe, 1'b1);
    check("rd_data_at_k3", data_bus, 16'hA5A5);
    cyc(2);
    rd_n = 1'b1; cs_n = 1'b1;
    cyc(SS);
    check("rd_oe_held", dut.oe, 1'b1);
    cyc(1);
    check("rd_oe_released", dut.oe, 1'b0);
    cyc(SS);

    // ---------------- long strobe, data changes mid-strobe ----------------
    base = stb_cnt;
    addr = 8'd1; host_dat = 16'h1234; host_drv = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    cyc(10);
    host_dat = 16'hFFFF;
    cyc(10);
    wr_n = 1'b1; cs_n = 1'b1; host_drv = 1'b0;
    cyc(SS + 2);
    check("long_stb_count", stb_cnt - base, 1);
    check("long_ctrl1", ctrl_q[1*DW +: DW], 16'h1234);
    exp_ctrl[1*DW +: DW] = 16'h1234;

    // ---------------- interrupt set / clear ----------------
    host_write(8'(NREG + 2), 16'h0001);
    check("irq_idle", irq, 1'b0);
    irq_src = 16'h0001;
    cyc(1);
    irq_src = 16'h0000;
    check("irq_m1", irq, 1'b0);
    cyc(1);
    check("irq_m2", irq, 1'b1);
    host_read(8'(NREG + 1), rd_val);
    check("pend_read_set", rd_val, 16'h0001);
    host_write(8'(NREG + 1), 16'h0001);
    check("irq_after_w1c", irq, 1'b0);
    host_read(8'(NREG + 1), rd_val);
    check("pend_read_clr", rd_val, 16'h0000);

    // clear and set of bit 0 in the same cycle: set wins
    addr = 8'(NREG + 1); host_dat = 16'h0001; host_drv = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    cyc(SS);
    irq_src = 16'h0001;
    cyc(1);
    irq_src = 16'h0000;
    cyc(1);
    wr_n = 1'b1; cs_n = 1'b1; host_drv = 1'b0;
    cyc(SS + 2);
    host_read(8'(NREG + 1), rd_val);
    check("pend_set_wins", rd_val, 16'h0001);
    check("irq_set_wins", irq, 1'b1);
    host_write(8'(NREG + 1), 16'h0001);

    // ---------------- unmapped and status access ----------------
    host_read(8'hF0, rd_val);
    check("unmapped_read", rd_val, 16'h0000);
    host_write(8'hF0, 16'h5555);
    check("unmapped_wr_addr", wr_addr, 8'hF0);
    check("unmapped_ctrl", ctrl_q, exp_ctrl);
    host_read(8'(NREG + 2), rd_val);
    check("unmapped_en_kept", rd_val, 16'h0001);
    status_in = 16'hBEEF;
    host_read(8'(NREG), rd_val);
    check("status_read", rd_val, 16'hBEEF);
    host_write(8'(NREG), 16'h1111);
    check("status_wr_ctrl", ctrl_q, exp_ctrl);
    status_in = 16'h0000;

    // ---------------- illegal strobe combinations ----------------
    base = stb_cnt;
    addr = 8'd2; host_dat = 16'h7777; host_drv = 1'b1; cs_n = 1'b1; wr_n = 1'b0;
    cyc(SS + 2);
    wr_n = 1'b1; host_drv = 1'b0;
    cyc(SS + 2);
    check("no_cs_stb", stb_cnt - base, 0);
    check("no_cs_ctrl", ctrl_q, exp_ctrl);

    addr = 8'd3; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    cyc(SS + 3);
    check("both_low_oe", dut.oe, 1'b0);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    cyc(SS + 2);
    check("both_low_stb", stb_cnt - base, 0);
    check("both_low_ctrl", ctrl_q, exp_ctrl);

    // ---------------- reset mid-access ----------------
    irq_src = 16'h0001;
    cyc(1);
    irq_src = 16'h0000;
    cyc(2);
    check("pre_rst_irq", irq, 1'b1);
    addr = 8'd4; host_dat = 16'h4444; host_drv = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", ctrl_q, 128'h0);
    check("mid_rst_irq", irq, 1'b0);
    check("mid_rst_wr_addr", wr_addr, 8'h00);
    check("mid_rst_oe", dut.oe, 1'b0);
    cyc(2);
    base = stb_cnt;
    rst_n = 1'b1;
    cyc(SS);
    check("post_rst_before", ctrl_q[4*DW +: DW], 16'h0000);
    cyc(1);
    check("post_rst_commit", ctrl_q[4*DW +: DW], 16'h4444);
    check("post_rst_wr_stb", wr_stb, 1'b1);
    cyc(SS + 2);
    wr_n = 1'b1; cs_n = 1'b1; host_drv = 1'b0;
    cyc(SS + 2);
    check("post_rst_stb_count", stb_cnt - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
